// File: rtl/dds_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared constants, types and LUT-init helper for the DDS
//                phase-to-IQ path (radians-to-turns scale, quadrant type,
//                dither LFSR seed/taps, quarter-wave sine generator).
//  Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    // 1/(2*pi) scaled by 2^18, unsigned
    localparam int                   INV_2PI_W = 18;
    localparam logic [INV_2PI_W-1:0] INV_2PI   = 18'd41722;

    // Quadrant of the folded phase
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    // Dither LFSR: Fibonacci x^15 + x^14 + 1, taps are bit indices
    localparam int                LFSR_W      = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED   = 15'h0001;
    localparam int                LFSR_TAP_HI = 14;
    localparam int                LFSR_TAP_LO = 13;

    // Quarter-wave table entry k. The half-LSB address offset keeps the table
    // symmetric so that L[k] and L[~k] are exact sine/cosine complements.
    function automatic int quarter_sine(input int k, input int addr_w, input int out_w);
        real full_scale;
        real angle;
        full_scale = real'((1 << (out_w - 1)) - 1);
        angle      = (3.14159265358979323846 / 2.0) * (real'(k) + 0.5) / real'(1 << addr_w);
        return $rtoi(full_scale * $sin(angle) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/quarter_sine_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : quarter_sine_rom
//  Description : Dual-read quarter-wave sine table. Contents are generated at
//                elaboration from dds_pkg::quarter_sine; both read ports are
//                registered and qualified by ce. The table itself has no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module quarter_sine_rom
    import dds_pkg::*;
#(
    parameter int COARSE_ADDR_W = 9,
    parameter int OUT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic [COARSE_ADDR_W-1:0] i_addr_a,
    input  logic [COARSE_ADDR_W-1:0] i_addr_b,
    output logic [OUT_W-1:0]         o_data_a,
    output logic [OUT_W-1:0]         o_data_b
);

    localparam int DEPTH = 1 << COARSE_ADDR_W;

    logic [OUT_W-1:0] w_rom [DEPTH];
    logic [OUT_W-1:0] r_data_a;
    logic [OUT_W-1:0] r_data_b;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign w_rom[k] = OUT_W'(quarter_sine(k, COARSE_ADDR_W, OUT_W));
    end

    // Registered dual read; held while ce is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else if (ce) begin
            r_data_a <= w_rom[i_addr_a];
            r_data_b <= w_rom[i_addr_b];
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;

endmodule
`default_nettype wire

// File: rtl/phase_to_iq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : phase_to_iq
//  Description : Signed radian phase to quadrature sine/cosine. Four-stage
//                ce-qualified pipeline: radians->turns, quadrant fold,
//                quarter-wave LUT read, sign apply. Valid travels with data.
//                Optional macro PHASE_DITHER_EN adds LFSR dither to the turn
//                fraction before truncation to the LUT address.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_to_iq
    import dds_pkg::*;
#(
    parameter int PHASE_W       = 18,
    parameter int PHASE_POINT   = 16,
    parameter int COARSE_ADDR_W = 9,
    parameter int OUT_W         = 16,
    parameter int GUARD_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               i_valid,
    input  logic [PHASE_W-1:0] i_phase,
    output logic               o_valid,
    output logic [OUT_W-1:0]   o_sin,
    output logic [OUT_W-1:0]   o_cos
);

    localparam int TURN_W   = 2 + COARSE_ADDR_W + GUARD_W;
    localparam int PROD_W   = PHASE_W + INV_2PI_W + 1;
    localparam int TURN_MSB = PHASE_POINT + INV_2PI_W - 1;

    // S1: radians to turns
    logic signed [PROD_W-1:0] w_prod;
    logic [TURN_W-1:0]        w_turn;
    logic [TURN_W-1:0]        r_turn;
    logic                     r_valid1;

    // S2: fold
    logic [TURN_W-1:0]        w_turn_d;
    quadrant_t                r_q2;
    logic [COARSE_ADDR_W-1:0] r_addr;
    logic [COARSE_ADDR_W-1:0] r_naddr;
    logic                     r_valid2;

    // S3: LUT
    logic [OUT_W-1:0]         w_lut_a;
    logic [OUT_W-1:0]         w_lut_na;
    quadrant_t                r_q3;
    logic                     r_valid3;

    // S4: sign apply
    logic [OUT_W-1:0]         w_neg_a;
    logic [OUT_W-1:0]         w_neg_na;
    logic [OUT_W-1:0]         w_sin_next;
    logic [OUT_W-1:0]         w_cos_next;
    logic [OUT_W-1:0]         r_sin;
    logic [OUT_W-1:0]         r_cos;
    logic                     r_valid4;

    // Integer turns and bits below the turn field carry no information
    logic w_unused_prod;
    logic w_unused_guard;

    // Phase times 1/(2*pi); keeping only fraction bits wraps modulo one turn
    assign w_prod = PROD_W'($signed(i_phase)) * PROD_W'($signed({1'b0, INV_2PI}));
    assign w_turn = w_prod[TURN_MSB -: TURN_W];
    assign w_unused_prod = ^{w_prod[PROD_W-1:TURN_MSB+1], w_prod[TURN_MSB-TURN_W:0]};

    // Stage 1 register: turn fraction and valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_turn   <= '0;
            r_valid1 <= 1'b0;
        end else if (ce) begin
            r_turn   <= w_turn;
            r_valid1 <= i_valid;
        end
    end

`ifdef PHASE_DITHER_EN
    logic [LFSR_W-1:0] r_lfsr;
    logic              w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO];

    // Free-running dither source, advances on every enabled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (ce) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
        end
    end

    // Dither lands in the guard field; its carry wraps through address and quadrant
    assign w_turn_d = r_turn + TURN_W'(r_lfsr[GUARD_W-1:0]);
`else
    assign w_turn_d = r_turn;
`endif

    // Guard bits are truncated away here
    assign w_unused_guard = ^w_turn_d[GUARD_W-1:0];

    // Stage 2 register: quadrant, LUT address and its complement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q2     <= Q0;
            r_addr   <= '0;
            r_naddr  <= '0;
            r_valid2 <= 1'b0;
        end else if (ce) begin
            r_q2     <= quadrant_t'(w_turn_d[TURN_W-1 -: 2]);
            r_addr   <= w_turn_d[GUARD_W +: COARSE_ADDR_W];
            r_naddr  <= ~w_turn_d[GUARD_W +: COARSE_ADDR_W];
            r_valid2 <= r_valid1;
        end
    end

    quarter_sine_rom #(
        .COARSE_ADDR_W (COARSE_ADDR_W),
        .OUT_W         (OUT_W)
    ) u_rom (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .i_addr_a (r_addr),
        .i_addr_b (r_naddr),
        .o_data_a (w_lut_a),
        .o_data_b (w_lut_na)
    );

    // Stage 3 register: quadrant and valid alongside the LUT read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q3     <= Q0;
            r_valid3 <= 1'b0;
        end else if (ce) begin
            r_q3     <= r_q2;
            r_valid3 <= r_valid2;
        end
    end

    // LUT entries never exceed full scale, so plain negation cannot overflow
    assign w_neg_a  = -w_lut_a;
    assign w_neg_na = -w_lut_na;

    // Unfold quarter-wave magnitudes into signed sine/cosine
    always_comb begin
        w_sin_next = w_lut_a;
        w_cos_next = w_lut_na;
        case (r_q3)
            Q0: begin w_sin_next = w_lut_a;  w_cos_next = w_lut_na; end
            Q1: begin w_sin_next = w_lut_na; w_cos_next = w_neg_a;  end
            Q2: begin w_sin_next = w_neg_a;  w_cos_next = w_neg_na; end
            Q3: begin w_sin_next = w_neg_na; w_cos_next = w_lut_a;  end
            default: ;
        endcase
    end

    // Stage 4 register: outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sin    <= '0;
            r_cos    <= '0;
            r_valid4 <= 1'b0;
        end else if (ce) begin
            r_sin    <= w_sin_next;
            r_cos    <= w_cos_next;
            r_valid4 <= r_valid3;
        end
    end

    assign o_valid = r_valid4;
    assign o_sin   = r_sin;
    assign o_cos   = r_cos;

endmodule
`default_nettype wire

// File: tb/tb_phase_to_iq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_phase_to_iq
//  Description : Directed self-checking bench for phase_to_iq (default build).
//                A four-deep valid/phase pipeline model advanced on ce=1 edges
//                supplies the expected output timing; hand-computed values
//                cover quadrant corners, a real-valued sine covers sweeps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_to_iq;

    localparam int  PHASE_W = 18;
    localparam int  OUT_W   = 16;
    localparam int  FULL    = 32767;
    localparam real TOL     = 1.0 + (2.0 * 3.14159265358979 / 2048.0) * 32767.0;

    logic               clk     = 1'b0;
    logic               reset   = 1'b0;
    logic               ce      = 1'b0;
    logic               i_valid = 1'b0;
    logic [PHASE_W-1:0] i_phase = '0;
    logic               o_valid;
    logic [OUT_W-1:0]   o_sin;
    logic [OUT_W-1:0]   o_cos;

    int errors = 0;
    int checks = 0;

    // Expected pipeline occupancy: valid bit and phase per stage
    logic mv [4];
    int   mp [4];

    phase_to_iq dut (
        .clk     (clk),
        .reset   (reset),
        .ce      (ce),
        .i_valid (i_valid),
        .i_phase (i_phase),
        .o_valid (o_valid),
        .o_sin   (o_sin),
        .o_cos   (o_cos)
    );

    always #5 clk = ~clk;

    // Hand-computed results for phases landing on LUT entries 0/1/510/511
    function automatic bit known(input int p, output int s, output int c);
        known = 1'b1;
        case (p)
            0, 1:    begin s = 50;    c = FULL; end
            -1:      begin s = -50;   c = FULL; end
            202:     begin s = 151;   c = FULL; end
            -202:    begin s = -151;  c = FULL; end
            102944:  begin s = FULL;  c = -50;  end
            -102944: begin s = -FULL; c = -50;  end
            default: begin known = 1'b0; s = 0; c = 0; end
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [31:0] got, input real exp, input real tol);
        real d;
        checks++;
        d = $itor(got) - exp;
        if (d < 0.0) d = -d;
        assert (!$isunknown(got) && d <= tol)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0.1f +/- %0.1f", tag, got, exp, tol);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            mv[k] = 1'b0;
            mp[k] = 0;
        end
    endtask

    task automatic check_out();
        int es, ec;
        real ph, pw;
        logic signed [31:0] s32, c32;
        s32 = {{16{o_sin[15]}}, o_sin};
        c32 = {{16{o_cos[15]}}, o_cos};
        chk("o_valid", {31'b0, o_valid}, {31'b0, mv[3]});
        if (mv[3]) begin
            if (known(mp[3], es, ec)) begin
                chk("o_sin", s32, es);
                chk("o_cos", c32, ec);
            end else begin
                ph = real'(mp[3]) / 65536.0;
                chk_tol("sin_model", s32, real'(FULL) * $sin(ph), TOL);
                chk_tol("cos_model", c32, real'(FULL) * $cos(ph), TOL);
                pw = real'(s32) * real'(s32) + real'(c32) * real'(c32);
                checks++;
                assert (!$isunknown({s32, c32}) && pw >= 0.99 * 32767.0 * 32767.0 && pw <= 1.01 * 32767.0 * 32767.0)
                else begin
                    errors++;
                    $error("FAIL power: got %0.0f expected %0.0f +/- 1%%", pw, 32767.0 * 32767.0);
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model on ce=1 edges, sample after the edge
    task automatic cyc(input bit c, input bit v, input int p);
        ce      = c;
        i_valid = v;
        i_phase = PHASE_W'(p);
        @(posedge clk);
        if (c) begin
            for (int k = 3; k > 0; k--) begin
                mv[k] = mv[k-1];
                mp[k] = mp[k-1];
            end
            mv[0] = v;
            mp[0] = p;
        end
        #1;
        check_out();
    endtask

    int vec [8] = '{0, 202, 102944, -1, 0, -202, -102944, 1};
    bit pat [16] = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int idx;
        int t;
        clear_model();

        // Reset state
        reset = 1'b1;
        ce    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_sin", {{16{o_sin[15]}}, o_sin}, 0);
        chk("rst_cos", {{16{o_cos[15]}}, o_cos}, 0);
        reset = 1'b0;

        // Single sample: exactly four ce cycles of latency, then a bubble
        cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);

        // Back-to-back stream across all quadrants, including the turn wrap -1 -> 0
        for (int k = 0; k < 8; k++) cyc(1, 1, vec[k]);
        repeat (5) cyc(1, 0, 0);

        // Same stream with ce toggling; outputs must hold while ce=0
        idx = 0;
        t   = 0;
        while (idx < 8 && t < 64) begin
            cyc(pat[t % 16], 1, vec[idx]);
            if (pat[t % 16]) idx++;
            t++;
        end
        chk("ce_stream_consumed", idx, 8);
        repeat (12) begin
            cyc(pat[t % 16], 0, 0);
            t++;
        end

        // Asynchronous reset with samples in flight
        for (int k = 0; k < 6; k++) cyc(1, 1, vec[k]);
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, o_valid}, 0);
        chk("arst_sin", {{16{o_sin[15]}}, o_sin}, 0);
        chk("arst_cos", {{16{o_cos[15]}}, o_cos}, 0);
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1, 1, 102944);
        repeat (5) cyc(1, 0, 0);

        // Sweep the full input range against a real-valued model
        for (int p = -131072; p <= 131071; p += 1031) cyc(1, 1, p);
        repeat (5) cyc(1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
